// File: rtl/gf2m_result_unloader.sv
// rtl/gf2m_result_unloader.sv - captures a GF(2^m) product on done rise and streams it MSD-first
// Word 0 carries the zero-padded top digit; reset is synchronous active-high.
module gf2m_result_unloader #(
    parameter int DIGITAL    = 32,
    parameter int DATA_WIDTH = 163,
    parameter int IDXW       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_done,
    input  logic [DATA_WIDTH-1:0] in_t_i_j,
    output logic [DIGITAL-1:0]    out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [IDXW-1:0]       out_index,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam int              WORDS    = (DATA_WIDTH / DIGITAL) + 1;
    localparam int              PWIDTH   = WORDS * DIGITAL;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SEND = 2'b01
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_done_d;
    logic [PWIDTH-1:0]   r_shreg;
    logic [IDXW-1:0]     r_index;
    logic                r_overrun;
    logic                w_rise;
    logic                w_sending;
    logic                w_last;
    logic                w_xfer;

    assign w_rise    = in_done & ~r_done_d;
    assign w_sending = (r_state == S_SEND);
    assign w_last    = w_sending && (r_index == LAST_IDX);
    assign w_xfer    = w_sending & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = w_rise ? S_SEND : S_IDLE;
            S_SEND:  w_next = (w_xfer && w_last) ? S_IDLE : S_SEND;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_d  <= 1'b0;
            r_shreg   <= '0;
            r_index   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_done_d <= in_done;
            if ((r_state == S_IDLE) && w_rise) begin
                r_shreg <= PWIDTH'(in_t_i_j);
                r_index <= '0;
            end else if (w_xfer) begin
                // Clearing on the final word keeps out_data at zero while idle.
                if (w_last) begin
                    r_shreg <= '0;
                    r_index <= '0;
                end else begin
                    r_shreg <= r_shreg << DIGITAL;
                    r_index <= r_index + IDXW'(1);
                end
            end
            if (w_rise && w_sending) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_data  = r_shreg[PWIDTH-1 -: DIGITAL];
    assign out_valid = w_sending;
    assign busy      = w_sending;
    assign out_last  = w_last;
    assign out_index = r_index;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_gf2m_result_unloader.sv
// tb/tb_gf2m_result_unloader.sv - directed self-checking bench for gf2m_result_unloader
module tb_gf2m_result_unloader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_done = 1'b0;
    logic [162:0] in_t_i_j = '0;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;
    logic [3:0]   out_index;
    logic         busy;
    logic         overrun;
    logic         clr_overrun = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    gf2m_result_unloader dut (
        .clk         (clk),
        .rst         (rst),
        .in_done     (in_done),
        .in_t_i_j    (in_t_i_j),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_index   (out_index),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [31:0] exp_w [6];
    logic [31:0] ones_w [6];
    logic        ready_pat [9];

    initial begin
        int k;
        int budget;
        int extra_valid;

        exp_w  = '{32'h00000007, 32'h89ABCDEF, 32'h01234567,
                   32'hDEADBEEF, 32'hCAFEBABE, 32'h12345678};
        ones_w = '{32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset state
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_valid",   64'(out_valid), 64'd0);
        check("rst_busy",    64'(busy),      64'd0);
        check("rst_last",    64'(out_last),  64'd0);
        check("rst_index",   64'(out_index), 64'd0);
        check("rst_data",    64'(out_data),  64'd0);
        check("rst_overrun", 64'(overrun),   64'd0);

        // Basic stream with ready held high
        in_t_i_j  = 163'h7_89ABCDEF_01234567_DEADBEEF_CAFEBABE_12345678;
        out_ready = 1'b1;
        in_done   = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            check("basic_valid", 64'(out_valid), 64'd1);
            check("basic_busy",  64'(busy),      64'd1);
            check("basic_data",  64'(out_data),  64'(exp_w[i]));
            check("basic_index", 64'(out_index), 64'(i));
            check("basic_last",  64'(out_last),  64'(i == 5));
            tick();
        end
        check("basic_end_valid", 64'(out_valid), 64'd0);
        check("basic_end_busy",  64'(busy),      64'd0);
        in_done = 1'b0;
        tick();

        // Backpressure
        in_done = 1'b1;
        tick();
        k = 0;
        budget = 0;
        while (k < 6 && budget < 40) begin
            out_ready = (budget < 9) ? ready_pat[budget] : 1'b1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data",  64'(out_data),  64'(exp_w[k]));
            check("bp_index", 64'(out_index), 64'(k));
            if (out_ready) k++;
            tick();
            budget++;
        end
        check("bp_transfers", 64'(k),         64'd6);
        check("bp_cycles",    64'(budget),    64'd9);
        check("bp_end_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        in_done   = 1'b0;
        tick();

        // Overrun: new rise while word 3 is on the bus
        in_done = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            check("ovr_data",  64'(out_data),  64'(exp_w[i]));
            check("ovr_index", 64'(out_index), 64'(i));
            if (i == 2) in_done = 1'b0;
            if (i == 3) in_done = 1'b1;
            tick();
            if (i == 3) check("ovr_set", 64'(overrun), 64'd1);
        end
        check("ovr_end_valid", 64'(out_valid), 64'd0);
        tick();
        check("ovr_no_restart", 64'(out_valid), 64'd0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("ovr_cleared", 64'(overrun), 64'd0);

        // Clear and set on the same edge: set wins
        in_done = 1'b0;
        tick();
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        tick();
        in_done     = 1'b1;
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("ovr_set_wins", 64'(overrun), 64'd1);
        budget = 0;
        while (out_valid && budget < 20) begin
            tick();
            budget++;
        end
        check("ovr2_drained", 64'(out_valid), 64'd0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("ovr2_cleared", 64'(overrun), 64'd0);

        // Sticky done held for 20 cycles after the stream
        in_done = 1'b0;
        tick();
        in_done = 1'b1;
        tick();
        k = 0;
        budget = 0;
        while (out_valid && budget < 20) begin
            k++;
            tick();
            budget++;
        end
        check("sticky_words", 64'(k), 64'd6);
        extra_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) extra_valid++;
            tick();
        end
        check("sticky_no_second", 64'(extra_valid), 64'd0);
        check("sticky_overrun",   64'(overrun),     64'd0);

        // Reset mid-stream, then restart from held-high done with all-ones product
        in_done = 1'b0;
        tick();
        in_done = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("mid_word4", 64'(out_index), 64'd4);
        rst      = 1'b1;
        in_t_i_j = '1;
        tick();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy",  64'(busy),      64'd0);
        check("mid_rst_index", 64'(out_index), 64'd0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            check("ones_valid", 64'(out_valid), 64'd1);
            check("ones_data",  64'(out_data),  64'(ones_w[i]));
            check("ones_index", 64'(out_index), 64'(i));
            check("ones_last",  64'(out_last),  64'(i == 5));
            tick();
        end
        check("ones_end_valid", 64'(out_valid), 64'd0);
        check("ones_end_data",  64'(out_data),  64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
